// File: rtl/hififo_request_burst_pkg.sv
// hififo_request_burst_pkg: shared unit/boundary constants, burst state enum and unsigned min helpers
package hififo_request_burst_pkg;
   localparam int HIFIFO_BS = 3;
   localparam int HIFIFO_BOUNDARY = 4096;
   typedef enum logic [1:0] {IDLE, OFFER, ACK} burst_state_t;
   function automatic logic [31:0] min3(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
      return (a < b) ? ((a < c) ? a : c) : ((b < c) ? b : c);
   endfunction
   function automatic logic [31:0] min4(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                                        input logic [31:0] d);
      return min3((a < b) ? a : b, c, d);
   endfunction
endpackage

// File: rtl/hififo_request_burst_if.sv
// hififo_request_burst_if: producer request handshake plus burst offer towards the TLP generator
interface hififo_request_burst_if #(
   parameter int BS = 3,
   parameter int AMSB = 63,
   parameter int LMSB = 20,
   parameter int LW = 5
);
   logic [LMSB-BS:0] request_count;
   logic [AMSB:0] request_addr;
   logic request_valid;
   logic request_ack;
   logic burst_valid;
   logic [AMSB:0] burst_addr;
   logic [LW-1:0] burst_len;
   logic burst_ready;
   modport master (
      input request_count, request_addr, request_valid, burst_ready,
      output request_ack, burst_valid, burst_addr, burst_len
   );
   modport slave (
      output request_count, request_addr, request_valid, burst_ready,
      input request_ack, burst_valid, burst_addr, burst_len
   );
endinterface

// File: rtl/hififo_credit_counter.sv
// hififo_credit_counter: units committed to the downstream FIFO, +N on handshake, -1 on release, floor at 0
module hififo_credit_counter #(
   parameter int LW = 5,
   parameter int CW = 10
) (
   input logic clock,
   input logic reset,
   input logic add,
   input logic [LW-1:0] add_n,
   input logic sub,
   output logic [CW-1:0] outstanding
);
   logic [CW-1:0] sum;
   always_comb sum = outstanding + (add ? CW'(add_n) : CW'(0));
   always_ff @(posedge clock)
      outstanding <= reset ? '0 : sum - CW'(sub && sum != '0);
endmodule

// File: rtl/hififo_request_burst.sv
// hififo_request_burst: splits producer transfers into bursts bounded by length, address line and FIFO credit
module hififo_request_burst
   import hififo_request_burst_pkg::*;
#(
   parameter int BS = HIFIFO_BS,
   parameter int AMSB = 63,
   parameter int LMSB = 20,
   parameter int MAX_BURST = 16,
   parameter int BOUNDARY = HIFIFO_BOUNDARY,
   parameter int FIFO_UNITS = 512,
   localparam int LW = $clog2(MAX_BURST) + 1,
   localparam int CW = $clog2(FIFO_UNITS) + 1
) (
   input logic clock,
   input logic reset,
   hififo_request_burst_if.master bus,
   input logic unit_freed,
   input logic abort,
   output logic [CW-1:0] outstanding,
   output logic idle
);
   localparam int BW = $clog2(BOUNDARY);
   burst_state_t state;
   logic [LW-1:0] ack_cnt;
   logic [LW-1:0] n;
   logic [31:0] credits;
   logic [31:0] to_bound;
   logic handshake;
   // a start exactly on a line yields a full line, letting MAX_BURST limit instead
   always_comb begin
      credits = 32'(FIFO_UNITS) - 32'(outstanding);
      to_bound = 32'(BOUNDARY >> BS) - 32'(bus.request_addr[BW-1:BS]);
      n = LW'(min4(32'(bus.request_count), 32'(MAX_BURST), to_bound, credits));
      handshake = state == OFFER && bus.burst_valid && bus.burst_ready && !abort;
      idle = state == IDLE;
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
         bus.request_ack <= 1'b0;
         bus.burst_valid <= 1'b0;
         bus.burst_addr <= '0;
         bus.burst_len <= '0;
         ack_cnt <= '0;
      end else if (abort) begin
         state <= IDLE;
         bus.request_ack <= 1'b0;
         bus.burst_valid <= 1'b0;
         ack_cnt <= '0;
      end else begin
         case (state)
            IDLE:
               if (bus.request_valid && credits != 0) begin
                  bus.burst_addr <= bus.request_addr;
                  bus.burst_len <= n;
                  bus.burst_valid <= 1'b1;
                  state <= OFFER;
               end
            OFFER:
               if (bus.burst_ready) begin
                  bus.burst_valid <= 1'b0;
                  bus.request_ack <= 1'b1;
                  ack_cnt <= bus.burst_len;
                  state <= ACK;
               end
            ACK:
               // the IDLE cycle after the last ack lets the producer's count/address settle
               if (!bus.request_valid || ack_cnt <= 1) begin
                  bus.request_ack <= 1'b0;
                  ack_cnt <= '0;
                  state <= IDLE;
               end else begin
                  ack_cnt <= ack_cnt - 1'b1;
               end
            default: state <= IDLE;
         endcase
      end
   end
   hififo_credit_counter #(.LW(LW), .CW(CW)) u_credit (
      .clock(clock),
      .reset(reset),
      .add(handshake),
      .add_n(bus.burst_len),
      .sub(unit_freed),
      .outstanding(outstanding)
   );
endmodule
